// File: rtl/alu_pkg.sv
// Opcode encodings and FSM state type shared by the accumulator ALU.
// Every opcode is 4 bits wide.
package alu_pkg;

    localparam logic [3:0] OP_PASS0 = 4'd0;
    localparam logic [3:0] OP_PASS1 = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_PASSD = 4'd5;
    localparam logic [3:0] OP_PASS6 = 4'd6;
    localparam logic [3:0] OP_PASS7 = 4'd7;
    localparam logic [3:0] OP_MUL   = 4'd8;
    localparam logic [3:0] OP_SUB   = 4'd9;
    localparam logic [3:0] OP_SHL   = 4'd10;
    localparam logic [3:0] OP_SHR   = 4'd11;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier. It handles one multiplier bit per cycle, starting from the LSB.
// The product output already includes the current iteration, so it holds the final result while last is high.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;
    logic [2*WIDTH-1:0] addend;

    assign addend  = mplier_q[0] ? mcand_q : '0;
    assign product = acc_q + addend;
    assign last    = run_q && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (load) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_acc_seq.sv
// Registered accumulator ALU with start/busy/done handshake and carry/zero flags.
//   state   | meaning
//   IDLE    | accepts start; single-cycle ops complete on the sampling edge
//   MUL_RUN | shift-add multiply in progress, start ignored
module alu_acc_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] accum,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q;
    logic               zero_q, carry_q, done_q;
    logic [WIDTH:0]     sum_w, diff_w;
    logic [WIDTH-1:0]   alu_val, res_val;
    logic               alu_c, res_c, res_we, mul_load, mul_last;
    logic [2*WIDTH-1:0] product;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (mul_load),
        .a       (accum),
        .b       (data),
        .product (product),
        .last    (mul_last)
    );

    always_comb begin
        sum_w   = {1'b0, accum} + {1'b0, data};
        diff_w  = {1'b0, accum} - {1'b0, data};
        alu_val = accum;
        alu_c   = 1'b0;
        case (opcode)
            OP_ADD:   begin alu_val = sum_w[WIDTH-1:0];  alu_c = sum_w[WIDTH];    end
            OP_AND:   alu_val = accum & data;
            OP_XOR:   alu_val = accum ^ data;
            OP_PASSD: alu_val = data;
            OP_SUB:   begin alu_val = diff_w[WIDTH-1:0]; alu_c = diff_w[WIDTH];   end
            OP_SHL:   begin alu_val = {accum[WIDTH-2:0], 1'b0}; alu_c = accum[WIDTH-1]; end
            OP_SHR:   begin alu_val = {1'b0, accum[WIDTH-1:1]}; alu_c = accum[0];       end
            default:  ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mul_load = 1'b0;
        res_we   = 1'b0;
        res_val  = alu_val;
        res_c    = alu_c;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (opcode == OP_MUL) begin
                        mul_load = 1'b1;
                        state_d  = MUL_RUN;
                    end else begin
                        res_we = 1'b1;
                    end
                end
            end
            MUL_RUN: begin
                if (mul_last) begin
                    res_we  = 1'b1;
                    res_val = product[WIDTH-1:0];
                    res_c   = |product[2*WIDTH-1:WIDTH];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= res_we;
            if (res_we) begin
                out_q   <= res_val;
                zero_q  <= (res_val == '0);
                carry_q <= res_c;
            end
        end
    end

    assign out   = out_q;
    assign zero  = zero_q;
    assign carry = carry_q;
    assign done  = done_q;
    assign busy  = (state_q == MUL_RUN);

endmodule

// File: doc/alu_acc_seq.md
Name: alu_acc_seq

Overview:
Parametrised, registered successor to the combinational datapath ALU in the 8-bit RISC core.
- Adds SUB, shift and iterative multiply operations.
- Adds carry/zero flags registered alongside the result.
- Uses a start/busy/done handshake so the controller can stall on multi-cycle operations.
- Sits between the accumulator register and the accumulator write-back mux; the controller drives start from the execute state.

Parameters:
WIDTH, 8, datapath width of data, accum and out; legal range 2..32.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
opcode  input  4  operation select, sampled with start
data  input  WIDTH  operand B (memory/immediate)
accum  input  WIDTH  operand A (accumulator)
out  output  WIDTH  registered result, held between operations
zero  output  1  registered, 1 when out == 0
carry  output  1  registered carry/borrow/overflow flag
busy  output  1  high while a multi-cycle operation runs
done  output  1  one-cycle pulse, coincident with new out/flags

Behaviour:
- Reset (async, rst_n=0): out=0, zero=0, carry=0, busy=0, done=0, state=IDLE, iteration counter=0.
- Opcodes:
  - 0 PASS0: out=A
  - 1 PASS1: out=A
  - 2 ADD: out=A+B
  - 3 AND: out=A&B
  - 4 XOR: out=A^B
  - 5 PASSD: out=B
  - 6 PASS6: out=A
  - 7 PASS7: out=A
  - 8 MUL: out = low WIDTH bits of A*B
  - 9 SUB: out=A-B
  - 10 SHL: out=A<<1
  - 11 SHR: out=A>>1, logical
  - 12-15: out=A, carry=0
- Carry rules:
  - ADD: carry-out of the WIDTH-bit sum.
  - SUB: borrow, 1 when A<B unsigned.
  - SHL: A[WIDTH-1].
  - SHR: A[0].
  - MUL: 1 when the high WIDTH bits of the 2*WIDTH product are non-zero.
  - All other opcodes: carry=0.
- zero = (out == 0); it is registered on the same edge as out.
- out, zero and carry change only on the edge that raises done; otherwise they hold.
- States: IDLE, MUL_RUN.
- IDLE with start=1 and a non-MUL opcode, sampled at edge k:
  - result and flags are registered at edge k;
  - done=1 for the cycle following edge k;
  - state stays IDLE and busy stays 0;
  - back-to-back single-cycle operations may therefore issue every cycle.
- IDLE with start=1 and opcode MUL, sampled at edge k:
  - capture A, B and opcode into internal registers;
  - clear the partial product;
  - counter=0; busy=1 after edge k; state goes to MUL_RUN.
- MUL_RUN:
  - one shift-add iteration per cycle, least-significant multiplier bit first, 2*WIDTH-bit accumulator;
  - the counter increments each cycle;
  - on the edge where the counter reaches WIDTH-1 (edge k+WIDTH): register out/carry/zero, done=1, busy=0, state goes to IDLE;
  - busy is therefore high for exactly WIDTH cycles.
- Operands are captured at start. Changes to accum, data or opcode during MUL_RUN have no effect.
- start is ignored while busy=1: no queueing, no error.
- A start sampled in IDLE on the cycle done is high is accepted normally.
- done is never asserted for an ignored start.
- Reset asserted mid-MUL aborts the operation immediately. All outputs return to reset values and no done is produced.
- All arithmetic is unsigned. Internal add/sub width is WIDTH+1 to extract carry/borrow.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_PASS0..OP_SHR (4-bit);
  - the state enum {IDLE, MUL_RUN}.
- Sub-module alu_mul_seq holds the shift-add multiplier.
  - Interface: clk, rst_n, load, a, b, product[2*WIDTH-1:0], last.
  - The top level keeps the FSM, the single-cycle operation mux and the flag registers.

Test Plan:
- WIDTH=8, ADD, A=8'hF0, B=8'h20, start one cycle -> next cycle out=8'h10, carry=1, zero=0, done=1 for one cycle, busy never high.
- XOR A=8'h5A, B=8'h5A, then SUB A=8'h03, B=8'h05 on consecutive cycles -> out=8'h00/zero=1/carry=0, then out=8'hFE/zero=0/carry=1, done high two consecutive cycles.
- MUL A=8'h0F, B=8'h11 -> busy high exactly 8 cycles; done with out=8'hFF, carry=0, zero=0. Inputs changed mid-run do not alter the result.
- MUL A=8'h10, B=8'h10 -> out=8'h00, carry=1, zero=1. A start pulsed mid-run with opcode ADD is ignored: exactly one done, no extra result.
- Reset pulsed low at MUL iteration 4 -> out=0, flags 0, busy=0 immediately. No done follows. A fresh SHL A=8'h81 -> out=8'h02, carry=1.
- WIDTH=16: ADD 16'hFFFF+16'h0001 -> out=0, zero=1, carry=1. MUL 16'h0100*16'h0100 -> busy 16 cycles, out=0, carry=1.
